sccb_target: RTL and testbench

SCCB/I2C target (responder) that answers a bus master on `scl`/`sda` and maps bus transactions onto a simple 8-bit register port. It sits on the camera-bus side of the design. It serves two purposes: a stand-in camera for closed-loop simulation of the SCCB master, and an on-chip register window reachable over the same two wires. All bus signals are oversampled by `clk`; the block never drives `scl`.

---
 rtl/sccb_pkg.sv | 26 ++
 rtl/sccb_target_if.sv | 26 ++
 rtl/sccb_line_sync.sv | 45 ++++
 rtl/sccb_target.sv | 150 +++++++++++++++
 tb/tb_sccb_target.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sccb_pkg.sv
// Shared state encoding and bus constants for the SCCB target.
// The default device address 7'h21 yields write/read bytes 8'h42/8'h43.
package sccb_pkg;

    typedef enum logic [7:0] {
        IDLE,
        DEVADDR,
        DEVACK,
        SUBADDR,
        SUBACK,
        WDATA,
        WACK,
        RDATA,
        RACK,
        IGNORE
    } state_t;

    localparam logic [6:0] DEFAULT_DEV_ADDR = 7'h21;
    localparam logic [7:0] WRITE_BYTE       = 8'h42;
    localparam logic [7:0] READ_BYTE        = 8'h43;

    function automatic logic addr_match(input logic [7:0] b, input logic [6:0] dev);
        return b[7:1] == dev;
    endfunction

endpackage

// File: rtl/sccb_target_if.sv
// Register-port bundle between the SCCB target (master side) and a register file (slave side).
interface sccb_target_if;

    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic [7:0] reg_rdata;
    logic       reg_re;

    modport master (
        output reg_addr,
        output reg_wdata,
        output reg_we,
        output reg_re,
        input  reg_rdata
    );

    modport slave (
        input  reg_addr,
        input  reg_wdata,
        input  reg_we,
        input  reg_re,
        output reg_rdata
    );

endinterface

// File: rtl/sccb_line_sync.sv
// Two-flop synchronizers on scl/sda plus bit-edge and START/STOP detection.
// Flops reset high so an idle pulled-up bus never looks like a START after reset.
module sccb_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic scl,
    input  logic sda,
    output logic scl_s,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic scl_m, sda_m, scl_d, sda_d;
    logic sda_chg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scl_m <= 1'b1;
            scl_s <= 1'b1;
            scl_d <= 1'b1;
            sda_m <= 1'b1;
            sda_s <= 1'b1;
            sda_d <= 1'b1;
        end else begin
            scl_m <= scl;
            scl_s <= scl_m;
            scl_d <= scl_s;
            sda_m <= sda;
            sda_s <= sda_m;
            sda_d <= sda_s;
        end
    end

    // An scl edge only counts as a bit edge when sda held still, so bit edges
    // and START/STOP are mutually exclusive in any one cycle.
    assign sda_chg   = sda_s ^ sda_d;
    assign scl_rise  = scl_s & ~scl_d & ~sda_chg;
    assign scl_fall  = ~scl_s & scl_d & ~sda_chg;
    assign start_det = scl_s & sda_d & ~sda_s;
    assign stop_det  = scl_s & ~sda_d & sda_s;

endmodule

// File: rtl/sccb_target.sv
// SCCB/I2C target mapping bus transactions onto an 8-bit register port.
// Oversamples scl/sda with clk; drives sda open-drain only, never scl.
module sccb_target
    import sccb_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = DEFAULT_DEV_ADDR
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          scl,
    inout  wire           sda,
    sccb_target_if.master regs,
    output logic          busy,
    output logic [31:0]   debug_out
);

    state_t     state, state_next;
    logic       scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;
    logic [3:0] bit_cnt;
    logic [7:0] shift, ptr, wdata;
    logic       we, re, rw, drive;
    logic [7:0] byte_in;
    logic       last_bit, ack_done, addr_hit;
    logic       drive_next, we_fire, re_fire, ptr_inc, ptr_load, dev_hit;

    sccb_line_sync u_sync (
        .clk       (clk),
        .rst       (rst),
        .scl       (scl),
        .sda       (sda),
        .scl_s     (scl_s),
        .sda_s     (sda_s),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    assign byte_in  = {shift[6:0], sda_s};
    assign last_bit = scl_rise && (bit_cnt == 4'd7);
    // An ACK slot ends on the first fall seen while already pulling low.
    assign ack_done = scl_fall && drive;
    assign addr_hit = addr_match(byte_in, DEV_ADDR);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (start_det) begin
            state_next = DEVADDR;
        end else if (stop_det) begin
            state_next = IDLE;
        end else begin
            case (state)
                DEVADDR: if (last_bit) state_next = addr_hit ? DEVACK : IGNORE;
                DEVACK:  if (ack_done) state_next = rw ? RDATA : SUBADDR;
                SUBADDR: if (last_bit) state_next = SUBACK;
                SUBACK:  if (ack_done) state_next = WDATA;
                WDATA:   if (last_bit) state_next = WACK;
                WACK:    if (ack_done) state_next = WDATA;
                RDATA:   if (scl_fall && bit_cnt == 4'd8) state_next = RACK;
                RACK:    if (scl_fall) state_next = shift[0] ? IGNORE : RDATA;
                default: state_next = state;
            endcase
        end
    end

    always_comb begin
        drive_next = drive;
        we_fire    = 1'b0;
        re_fire    = 1'b0;
        ptr_inc    = 1'b0;
        ptr_load   = 1'b0;
        dev_hit    = 1'b0;
        case (state)
            DEVADDR: dev_hit  = last_bit && addr_hit;
            DEVACK:  re_fire  = ack_done && rw;
            SUBADDR: ptr_load = last_bit;
            WDATA:   we_fire  = last_bit;
            WACK:    ptr_inc  = ack_done;
            RACK: begin
                re_fire = scl_fall && !shift[0];
                ptr_inc = scl_fall && !shift[0];
            end
            default: ;
        endcase
        // First read bit goes out in the cycle right after the read strobe.
        if (start_det || stop_det) begin
            drive_next = 1'b0;
        end else if (re) begin
            drive_next = ~regs.reg_rdata[7];
        end else if (scl_fall) begin
            case (state)
                DEVACK, SUBACK, WACK: drive_next = ~drive;
                RDATA:                drive_next = (bit_cnt == 4'd8) ? 1'b0 : ~shift[6];
                default:              drive_next = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drive   <= 1'b0;
            we      <= 1'b0;
            re      <= 1'b0;
            rw      <= 1'b0;
            busy    <= 1'b0;
            bit_cnt <= '0;
            shift   <= '0;
            ptr     <= '0;
            wdata   <= '0;
        end else begin
            drive <= drive_next;
            we    <= we_fire;
            re    <= re_fire;
            if (dev_hit) rw <= byte_in[0];
            if (stop_det) busy <= 1'b0;
            else if (dev_hit) busy <= 1'b1;
            if (ptr_load) ptr <= byte_in;
            else if (ptr_inc) ptr <= ptr + 8'd1;
            if (we_fire) wdata <= byte_in;
            if (re) shift <= regs.reg_rdata;
            else if (scl_fall && state == RDATA) shift <= {shift[6:0], 1'b0};
            else if (scl_rise && (state inside {DEVADDR, SUBADDR, WDATA, RACK})) shift <= byte_in;
            if (start_det || re_fire) begin
                bit_cnt <= '0;
            end else if (scl_rise) begin
                case (state)
                    DEVADDR, SUBADDR, WDATA: bit_cnt <= last_bit ? 4'd0 : bit_cnt + 4'd1;
                    RDATA:                   bit_cnt <= bit_cnt + 4'd1;
                    default: ;
                endcase
            end
        end
    end

    assign sda             = drive ? 1'b0 : 1'bz;
    assign regs.reg_addr   = ptr;
    assign regs.reg_wdata  = wdata;
    assign regs.reg_we     = we;
    assign regs.reg_re     = re;
    assign debug_out       = {8'(state), 2'b00, drive, sda_s, scl_s, busy, rw, 1'b0, shift, ptr};

endmodule

// File: tb/tb_sccb_target.sv
// Directed bench for sccb_target: a bit-banged bus master plus strobe monitors.
module tb_sccb_target;
    import sccb_pkg::*;

    localparam int Q = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        scl;
    logic        m_low;
    logic [7:0]  rd_base;
    logic        busy;
    logic [31:0] debug_out;
    wire         sda;
    int          checks = 0;
    int          errors = 0;

    int         we_cnt = 0, re_cnt = 0, low_cnt = 0;
    logic [7:0] we_addr_q[$], we_data_q[$], re_addr_q[$];

    sccb_target_if bus();

    pullup (sda);
    assign sda = m_low ? 1'b0 : 1'bz;
    // Register file model: read data is a fixed offset from the pointer.
    assign bus.reg_rdata = rd_base + bus.reg_addr;

    sccb_target #(.DEV_ADDR(7'h21)) dut (
        .clk       (clk),
        .rst       (rst),
        .scl       (scl),
        .sda       (sda),
        .regs      (bus),
        .busy      (busy),
        .debug_out (debug_out)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.reg_we) begin
            we_cnt++;
            we_addr_q.push_back(bus.reg_addr);
            we_data_q.push_back(bus.reg_wdata);
        end
        if (bus.reg_re) begin
            re_cnt++;
            re_addr_q.push_back(bus.reg_addr);
        end
        if (sda === 1'b0 && !m_low) low_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_bit(input logic b, output logic r);
        @(negedge clk);
        m_low = ~b;
        tick(Q);
        scl = 1'b1;
        tick(Q);
        r = sda;
        tick(Q);
        scl = 1'b0;
        tick(Q);
    endtask

    task automatic bus_start;
        @(negedge clk);
        m_low = 1'b0;
        tick(Q);
        scl = 1'b1;
        tick(Q);
        m_low = 1'b1;
        tick(Q);
        scl = 1'b0;
        tick(Q);
    endtask

    task automatic bus_stop;
        @(negedge clk);
        m_low = 1'b1;
        tick(Q);
        scl = 1'b1;
        tick(Q);
        m_low = 1'b0;
        tick(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) bus_bit(b[i], r);
        bus_bit(1'b1, ack);
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            bus_bit(1'b1, r);
            d[i] = r;
        end
        bus_bit(mack, r);
    endtask

    task automatic test_reset;
        rst = 1'b0; scl = 1'b1; m_low = 1'b0; rd_base = 8'h00;
        tick(3);
        checks++; if (sda !== 1'b1) begin errors++; $display("FAIL reset_sda got=%b exp=1", sda); end
        checks++; if (debug_out !== 32'h0018_0000) begin errors++; $display("FAIL reset_debug got=%h exp=00180000", debug_out); end
        checks++; if (bus.reg_addr !== 8'h00) begin errors++; $display("FAIL reset_addr got=%h exp=00", bus.reg_addr); end
        checks++; if (bus.reg_wdata !== 8'h00) begin errors++; $display("FAIL reset_wdata got=%h exp=00", bus.reg_wdata); end
        checks++; if ({bus.reg_we, bus.reg_re, busy} !== 3'b000) begin errors++; $display("FAIL reset_strobes got=%b exp=000", {bus.reg_we, bus.reg_re, busy}); end
        rst = 1'b1;
        tick(4);
    endtask

    task automatic test_write;
        logic a0, a1, a2;
        int w0 = we_cnt;
        int lq = we_addr_q.size();
        bus_start;
        write_byte(WRITE_BYTE, a0);
        write_byte(8'h12, a1);
        write_byte(8'h80, a2);
        checks++; if ({a0, a1, a2} !== 3'b000) begin errors++; $display("FAIL write_acks got=%b exp=000", {a0, a1, a2}); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL write_busy_mid got=%b exp=1", busy); end
        bus_stop;
        tick(4);
        checks++; if (we_cnt - w0 != 1) begin errors++; $display("FAIL write_we_count got=%0d exp=1", we_cnt - w0); end
        checks++; if (we_addr_q[lq] !== 8'h12) begin errors++; $display("FAIL write_we_addr got=%h exp=12", we_addr_q[lq]); end
        checks++; if (we_data_q[lq] !== 8'h80) begin errors++; $display("FAIL write_we_data got=%h exp=80", we_data_q[lq]); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL write_busy_after_stop got=%b exp=0", busy); end
        checks++; if (bus.reg_addr !== 8'h13) begin errors++; $display("FAIL write_ptr_inc got=%h exp=13", bus.reg_addr); end
    endtask

    task automatic test_two_phase_read;
        logic a0, a1, a2;
        logic [7:0] d;
        int r0, rq;
        rd_base = 8'h9B;
        bus_start;
        write_byte(WRITE_BYTE, a0);
        write_byte(8'h0A, a1);
        bus_stop;
        tick(4);
        checks++; if (bus.reg_addr !== 8'h0A) begin errors++; $display("FAIL twophase_ptr got=%h exp=0a", bus.reg_addr); end
        r0 = re_cnt;
        rq = re_addr_q.size();
        bus_start;
        write_byte(READ_BYTE, a2);
        read_byte(1'b1, d);
        bus_stop;
        tick(4);
        checks++; if ({a0, a1, a2} !== 3'b000) begin errors++; $display("FAIL twophase_acks got=%b exp=000", {a0, a1, a2}); end
        checks++; if (d !== 8'hA5) begin errors++; $display("FAIL twophase_data got=%h exp=a5", d); end
        checks++; if (re_cnt - r0 != 1) begin errors++; $display("FAIL twophase_re_count got=%0d exp=1", re_cnt - r0); end
        checks++; if (re_addr_q[rq] !== 8'h0A) begin errors++; $display("FAIL twophase_re_addr got=%h exp=0a", re_addr_q[rq]); end
        checks++; if (bus.reg_addr !== 8'h0A) begin errors++; $display("FAIL twophase_nack_ptr got=%h exp=0a", bus.reg_addr); end
    endtask

    task automatic test_burst_read;
        logic a;
        logic [7:0] d0, d1;
        int r0 = re_cnt;
        bus_start;
        write_byte(READ_BYTE, a);
        read_byte(1'b0, d0);
        read_byte(1'b1, d1);
        bus_stop;
        tick(4);
        checks++; if (d0 !== 8'hA5) begin errors++; $display("FAIL burstrd_d0 got=%h exp=a5", d0); end
        checks++; if (d1 !== 8'hA6) begin errors++; $display("FAIL burstrd_d1 got=%h exp=a6", d1); end
        checks++; if (re_cnt - r0 != 2) begin errors++; $display("FAIL burstrd_re_count got=%0d exp=2", re_cnt - r0); end
        checks++; if (bus.reg_addr !== 8'h0B) begin errors++; $display("FAIL burstrd_ptr got=%h exp=0b", bus.reg_addr); end
    endtask

    task automatic test_wrong_addr;
        logic a0, a1;
        int l0 = low_cnt;
        int w0 = we_cnt;
        int r0 = re_cnt;
        bus_start;
        write_byte(8'h60, a0);
        write_byte(8'h00, a1);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wrongaddr_busy got=%b exp=0", busy); end
        bus_stop;
        tick(4);
        checks++; if ({a0, a1} !== 2'b11) begin errors++; $display("FAIL wrongaddr_nack got=%b exp=11", {a0, a1}); end
        checks++; if (low_cnt != l0) begin errors++; $display("FAIL wrongaddr_drive got=%0d exp=%0d", low_cnt, l0); end
        checks++; if ((we_cnt - w0) + (re_cnt - r0) != 0) begin errors++; $display("FAIL wrongaddr_strobes got=%0d exp=0", (we_cnt - w0) + (re_cnt - r0)); end
        checks++; if (debug_out[31:24] !== 8'(IDLE)) begin errors++; $display("FAIL wrongaddr_state got=%h exp=00", debug_out[31:24]); end
    endtask

    task automatic test_burst_write;
        logic a0, a1, a2, a3, a4;
        int w0 = we_cnt;
        int lq = we_addr_q.size();
        bus_start;
        write_byte(WRITE_BYTE, a0);
        write_byte(8'hFE, a1);
        write_byte(8'h11, a2);
        write_byte(8'h22, a3);
        write_byte(8'h33, a4);
        bus_stop;
        tick(4);
        checks++; if ({a0, a1, a2, a3, a4} !== 5'b00000) begin errors++; $display("FAIL burstwr_acks got=%b exp=00000", {a0, a1, a2, a3, a4}); end
        checks++; if (we_cnt - w0 != 3) begin errors++; $display("FAIL burstwr_we_count got=%0d exp=3", we_cnt - w0); end
        checks++; if ({we_addr_q[lq], we_addr_q[lq+1], we_addr_q[lq+2]} !== 24'hFEFF00) begin errors++; $display("FAIL burstwr_addrs got=%h exp=feff00", {we_addr_q[lq], we_addr_q[lq+1], we_addr_q[lq+2]}); end
        checks++; if ({we_data_q[lq], we_data_q[lq+1], we_data_q[lq+2]} !== 24'h112233) begin errors++; $display("FAIL burstwr_data got=%h exp=112233", {we_data_q[lq], we_data_q[lq+1], we_data_q[lq+2]}); end
        checks++; if (bus.reg_addr !== 8'h01) begin errors++; $display("FAIL burstwr_ptr_wrap got=%h exp=01", bus.reg_addr); end
    endtask

    task automatic test_repeated_start;
        logic a, r;
        int w0 = we_cnt;
        int lq = we_addr_q.size();
        bus_start;
        write_byte(WRITE_BYTE, a);
        write_byte(8'h20, a);
        bus_bit(1'b1, r);
        bus_bit(1'b0, r);
        bus_bit(1'b1, r);
        bus_bit(1'b0, r);
        bus_start;
        write_byte(WRITE_BYTE, a);
        write_byte(8'h30, a);
        write_byte(8'h5A, a);
        bus_stop;
        tick(4);
        checks++; if (we_cnt - w0 != 1) begin errors++; $display("FAIL rstart_we_count got=%0d exp=1", we_cnt - w0); end
        checks++; if ({we_addr_q[lq], we_data_q[lq]} !== 16'h305A) begin errors++; $display("FAIL rstart_we got=%h exp=305a", {we_addr_q[lq], we_data_q[lq]}); end
    endtask

    task automatic test_reset_mid_read;
        logic a0, a1, a2, a3;
        int w0, lq;
        rd_base = 8'h00;
        bus_start;
        write_byte(WRITE_BYTE, a0);
        write_byte(8'h40, a0);
        bus_stop;
        tick(4);
        bus_start;
        write_byte(READ_BYTE, a0);
        tick(2);
        checks++; if (sda !== 1'b0) begin errors++; $display("FAIL midread_drive got=%b exp=0", sda); end
        checks++; if (debug_out[31:24] !== 8'(RDATA)) begin errors++; $display("FAIL midread_state got=%h exp=07", debug_out[31:24]); end
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checks++; if (sda !== 1'b1 || debug_out[21] !== 1'b0) begin errors++; $display("FAIL midread_async_release got=%b%b exp=10", sda, debug_out[21]); end
        tick(2);
        checks++; if (debug_out !== 32'h0018_0000) begin errors++; $display("FAIL midread_debug got=%h exp=00180000", debug_out); end
        checks++; if ({bus.reg_addr, bus.reg_wdata} !== 16'h0000) begin errors++; $display("FAIL midread_regs got=%h exp=0000", {bus.reg_addr, bus.reg_wdata}); end
        checks++; if ({bus.reg_we, bus.reg_re, busy} !== 3'b000) begin errors++; $display("FAIL midread_strobes got=%b exp=000", {bus.reg_we, bus.reg_re, busy}); end
        rst = 1'b1;
        tick(2);
        scl = 1'b1;
        tick(4);
        w0 = we_cnt;
        lq = we_addr_q.size();
        bus_start;
        write_byte(WRITE_BYTE, a1);
        write_byte(8'h05, a2);
        write_byte(8'h9C, a3);
        bus_stop;
        tick(4);
        checks++; if ({a1, a2, a3} !== 3'b000) begin errors++; $display("FAIL postreset_acks got=%b exp=000", {a1, a2, a3}); end
        checks++; if (we_cnt - w0 != 1) begin errors++; $display("FAIL postreset_we_count got=%0d exp=1", we_cnt - w0); end
        checks++; if ({we_addr_q[lq], we_data_q[lq]} !== 16'h059C) begin errors++; $display("FAIL postreset_we got=%h exp=059c", {we_addr_q[lq], we_data_q[lq]}); end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_write;
        test_two_phase_read;
        test_burst_read;
        test_wrong_addr;
        test_burst_write;
        test_repeated_start;
        test_reset_mid_read;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
